// File: rtl/conv_tile_scheduler.sv
// Purpose: walks out-channel tiles, in-channel tiles, rows and cols of one conv layer, with a csync (filter load) phase before each in-channel tile.
// Latency: all outputs are registered; a pixel appears one cycle after i_data_ready is sampled high in DATA.
// Backpressure: i_data_ready low holds the counters and suppresses data_run; i_pe_csync_done gates leaving CSYNC.
module conv_tile_scheduler #(
  parameter int W_SIZE    = 8,
  parameter int W_CHANNEL = 8,
  parameter int DRAIN_CYC = 15
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 i_start,
  input  logic [W_SIZE-1:0]    i_width,
  input  logic [W_SIZE-1:0]    i_height,
  input  logic [W_CHANNEL-1:0] i_q_channel,
  input  logic [W_CHANNEL-1:0] i_q_chn_out,
  input  logic                 i_data_ready,
  input  logic                 i_pe_csync_done,
  output logic                 o_ctrl_csync_run,
  output logic                 o_ctrl_data_run,
  output logic [W_SIZE-1:0]    o_row,
  output logic [W_SIZE-1:0]    o_col,
  output logic [W_CHANNEL-1:0] o_chn,
  output logic [W_CHANNEL-1:0] o_chn_out,
  output logic                 o_is_first_row,
  output logic                 o_is_last_row,
  output logic                 o_is_first_col,
  output logic                 o_is_last_col,
  output logic                 o_is_first_chn,
  output logic                 o_is_last_chn,
  output logic                 o_busy,
  output logic                 o_done
);

  typedef enum logic [1:0] {S_IDLE, S_CSYNC, S_DATA, S_DRAIN} state_t;

  localparam int                   W_DRN = $clog2(DRAIN_CYC + 1);
  localparam logic [W_SIZE-1:0]    ONE_S = 1;
  localparam logic [W_CHANNEL-1:0] ONE_C = 1;
  localparam logic [W_DRN-1:0]     DRN_LAST = W_DRN'(DRAIN_CYC);

  state_t                 state, state_nxt;
  logic [W_SIZE-1:0]      cfg_w, cfg_h, row, col, row_nxt, col_nxt;
  logic [W_CHANNEL-1:0]   cfg_qc, cfg_qo, chn, cout, chn_nxt, cout_nxt;
  logic [W_DRN-1:0]       drn_cnt, drn_nxt;
  logic                   load_cfg, emit, csync_nxt, data_nxt, done_nxt;
  logic                   lst_row, lst_col, lst_chn, lst_cout;

  assign lst_row  = (row  == cfg_h  - ONE_S);
  assign lst_col  = (col  == cfg_w  - ONE_S);
  assign lst_chn  = (chn  == cfg_qc - ONE_C);
  assign lst_cout = (cout == cfg_qo - ONE_C);

  // Next-state, counter advance and registered-output intent.
  always_comb begin
    state_nxt = state;
    row_nxt   = row;
    col_nxt   = col;
    chn_nxt   = chn;
    cout_nxt  = cout;
    drn_nxt   = '0;
    load_cfg  = 1'b0;
    emit      = 1'b0;
    csync_nxt = 1'b0;
    data_nxt  = 1'b0;
    done_nxt  = 1'b0;
    case (state)
      S_IDLE: begin
        if (i_start) begin
          if (i_width != '0 && i_height != '0 && i_q_channel != '0 && i_q_chn_out != '0) begin
            load_cfg  = 1'b1;
            row_nxt   = '0;
            col_nxt   = '0;
            chn_nxt   = '0;
            cout_nxt  = '0;
            state_nxt = S_CSYNC;
          end else begin
            done_nxt = 1'b1;
          end
        end
      end
      S_CSYNC: begin
        // Coordinates already point at (0,0) of the upcoming tile; first CSYNC
        // cycle keeps csync_run low so the PE engine always sees a fresh edge.
        emit = 1'b1;
        if (o_ctrl_csync_run && i_pe_csync_done) begin
          state_nxt = S_DATA;
        end else begin
          csync_nxt = 1'b1;
        end
      end
      S_DATA: begin
        if (i_data_ready) begin
          emit     = 1'b1;
          data_nxt = 1'b1;
          col_nxt  = lst_col ? '0 : col + ONE_S;
          if (lst_col) begin
            row_nxt = lst_row ? '0 : row + ONE_S;
            if (lst_row) begin
              if (!lst_chn) begin
                chn_nxt   = chn + ONE_C;
                state_nxt = S_CSYNC;
              end else if (!lst_cout) begin
                chn_nxt   = '0;
                cout_nxt  = cout + ONE_C;
                state_nxt = S_CSYNC;
              end else begin
                state_nxt = S_DRAIN;
              end
            end
          end
        end
      end
      S_DRAIN: begin
        drn_nxt = drn_cnt + 1'b1;
        if (drn_cnt == DRN_LAST) begin
          drn_nxt   = '0;
          done_nxt  = 1'b1;
          state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // State, counters and configuration registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state   <= S_IDLE;
      row     <= '0;
      col     <= '0;
      chn     <= '0;
      cout    <= '0;
      drn_cnt <= '0;
      cfg_w   <= '0;
      cfg_h   <= '0;
      cfg_qc  <= '0;
      cfg_qo  <= '0;
    end else begin
      state   <= state_nxt;
      row     <= row_nxt;
      col     <= col_nxt;
      chn     <= chn_nxt;
      cout    <= cout_nxt;
      drn_cnt <= drn_nxt;
      if (load_cfg) begin
        cfg_w  <= i_width;
        cfg_h  <= i_height;
        cfg_qc <= i_q_channel;
        cfg_qo <= i_q_chn_out;
      end
    end
  end

  // Registered outputs; coordinates and flags hold when nothing is emitted.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      o_ctrl_csync_run <= 1'b0;
      o_ctrl_data_run  <= 1'b0;
      o_busy           <= 1'b0;
      o_done           <= 1'b0;
      o_row            <= '0;
      o_col            <= '0;
      o_chn            <= '0;
      o_chn_out        <= '0;
      o_is_first_row   <= 1'b0;
      o_is_last_row    <= 1'b0;
      o_is_first_col   <= 1'b0;
      o_is_last_col    <= 1'b0;
      o_is_first_chn   <= 1'b0;
      o_is_last_chn    <= 1'b0;
    end else begin
      o_ctrl_csync_run <= csync_nxt;
      o_ctrl_data_run  <= data_nxt;
      o_busy           <= (state_nxt != S_IDLE);
      o_done           <= done_nxt;
      if (emit) begin
        o_row          <= row;
        o_col          <= col;
        o_chn          <= chn;
        o_chn_out      <= cout;
        o_is_first_row <= (row == '0);
        o_is_last_row  <= lst_row;
        o_is_first_col <= (col == '0);
        o_is_last_col  <= lst_col;
        o_is_first_chn <= (chn == '0);
        o_is_last_chn  <= lst_chn;
      end
    end
  end

endmodule

// File: doc/conv_tile_scheduler.md
Name: conv_tile_scheduler

Overview:
- Sequences one convolution layer through the PE engine.
- Walks output-channel tiles, then input-channel tiles, then rows and columns of the feature map.
- At the start of each input-channel tile it runs a csync phase so the PE engine can load filters, then streams one pixel coordinate per cycle with position flags.
- Sits between the layer-level controller (start/config) and the PE engine / buffer managers (data_run, csync_run, coordinates).

Parameters:
- W_SIZE, 8, width of row/col counters and image dimensions
- W_CHANNEL, 8, width of channel-tile counters and tile counts
- DRAIN_CYC, 15, cycles to wait after the last pixel before signalling done; must be >= 1 and covers PE pipeline depth

Ports:
- clk  input  1  clock
- rstn  input  1  asynchronous active-low reset
- i_start  input  1  one-cycle start pulse; sampled only in IDLE
- i_width  input  W_SIZE  image width in pixels
- i_height  input  W_SIZE  image height in pixels
- i_q_channel  input  W_CHANNEL  number of input-channel tiles
- i_q_chn_out  input  W_CHANNEL  number of output-channel tiles
- i_data_ready  input  1  downstream can accept a pixel this cycle
- i_pe_csync_done  input  1  PE engine finished filter load
- o_ctrl_csync_run  output  1  csync phase active
- o_ctrl_data_run  output  1  valid pixel coordinate this cycle
- o_row  output  W_SIZE  current row
- o_col  output  W_SIZE  current column
- o_chn  output  W_CHANNEL  current input-channel tile
- o_chn_out  output  W_CHANNEL  current output-channel tile
- o_is_first_row, o_is_last_row, o_is_first_col, o_is_last_col  output  1 each  pixel position flags
- o_is_first_chn, o_is_last_chn  output  1 each  input-channel tile position flags
- o_busy  output  1  scheduler not in IDLE
- o_done  output  1  one-cycle layer-complete pulse

Behaviour:
- Clock and reset: single clock clk; reset rstn is asynchronous, active-low.
- Reset values: all outputs 0; state IDLE; all counters 0. Reset mid-operation aborts immediately; no o_done is produced.
- Output timing: all outputs are registered. Coordinates and flags are valid in the same cycle as o_ctrl_data_run.
- Flags: computed from the counters (row==0, row==height-1, col==0, col==width-1, chn==0, chn==q_channel-1). They are also driven during CSYNC, with row=col=0 and chn/chn_out equal to the upcoming tile.
- States: IDLE, CSYNC, DATA, DRAIN.
- IDLE:
  - On i_start with all four dimensions nonzero: latch config, clear counters, go to CSYNC; o_busy=1 from the next cycle.
  - On i_start with any dimension zero: o_done pulses the next cycle, no other activity, stay IDLE.
- CSYNC:
  - o_ctrl_csync_run=1 and o_ctrl_data_run=0.
  - When i_pe_csync_done=1 is sampled, go to DATA next cycle and drop o_ctrl_csync_run.
  - o_ctrl_csync_run is therefore always low for at least one cycle between tiles; the PE engine edge-detects it.
- DATA:
  - Each cycle with i_data_ready=1: o_ctrl_data_run=1 with the current coordinates, then advance col; col wraps at width-1 to 0 and row increments.
  - Cycle with i_data_ready=0: o_ctrl_data_run=0, counters hold.
  - After the pixel (height-1, width-1):
    - Not last chn: chn+1, go to CSYNC.
    - Last chn, not last chn_out: chn=0, chn_out+1, go to CSYNC.
    - Last chn and last chn_out: go to DRAIN.
- DRAIN:
  - Count DRAIN_CYC cycles with no runs.
  - o_done then pulses for 1 cycle, simultaneously with the return to IDLE (o_busy=0 in that cycle).
- i_start while busy: ignored.
- Config inputs: sampled only at the accepted start; later changes have no effect.
- i_pe_csync_done outside CSYNC: ignored.
- Counters: tile counters wrap per the loop order, no overflow beyond the configured counts. Maximum dimension 2^W_SIZE-1.
- Total data_run pulses per layer = width*height*q_channel*q_chn_out. Csync phases per layer = q_channel*q_chn_out.

Test Plan:
- Basic order: W=3, H=2, q_channel=2, q_chn_out=1, ready=1, csync_done=csync_run → 2 csync windows, 12 data_run pulses. Order is (r0,c0..c2),(r1,c0..c2) with chn=0, then the same with chn=1. Last-pixel flags on (1,2). o_done occurs exactly DRAIN_CYC+1 cycles after the last data_run.
- Backpressure: same config, i_data_ready toggling 1,0,1,0 → data_run only in ready cycles, coordinates held, still exactly 12 pulses in the same order.
- Csync wait: i_pe_csync_done asserted 5 cycles after csync_run rises → csync_run stays high 6 cycles, no data_run before it drops, data_run starts the next cycle.
- Multi out-tile: W=2, H=1, q_channel=1, q_chn_out=3 → 3 csyncs, chn_out 0,1,2, chn always 0 with first_chn=last_chn=1. csync_run is low at least 1 cycle between csyncs.
- Zero dims / start while busy: i_width=0 → o_done the next cycle, no runs. A second i_start during DATA → ignored, pulse count unchanged.
- Reset mid-DATA: rstn low at the 4th pixel → all outputs 0 asynchronously, no o_done. A new start afterwards runs the full sequence from (0,0,0,0).
